// File: rtl/zero_cmp_pkg.sv
// Shared types and elaboration helpers for the pipelined zero comparator.
// Tree geometry is derived here so every level agrees on its slice.
package zero_cmp_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NZ   = 2'd1,
    EQ   = 2'd2,
    NE   = 2'd3
  } cmp_mode_t;

  function automatic int levels(int width, int fanin);
    int l;
    int p;
    l = 1;
    p = fanin;
    while (p < width) begin
      p = p * fanin;
      l = l + 1;
    end
    return l;
  endfunction

  function automatic int padded_width(int width, int fanin);
    int p;
    p = 1;
    for (int i = 0; i < levels(width, fanin); i++)
      p = p * fanin;
    return p;
  endfunction

  function automatic int level_width(int width, int fanin, int k);
    int w;
    w = padded_width(width, fanin);
    for (int i = 0; i < k; i++)
      w = w / fanin;
    return w;
  endfunction

  // Levels are packed back to back in one flat bus, level 0 at bit 0.
  function automatic int level_offset(int width, int fanin, int k);
    int o;
    o = 0;
    for (int i = 0; i < k; i++)
      o = o + level_width(width, fanin, i);
    return o;
  endfunction

endpackage

// File: rtl/zero_cmp_pipe_or_reduce_stage.sv
// One registered level of the OR tree: each output bit is the OR of
// FANIN adjacent input bits, loaded only while the pipe advances.
module or_reduce_stage #(
  parameter int N_IN  = 16,
  parameter int FANIN = 4
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic [N_IN-1:0]        d,
  output logic [N_IN/FANIN-1:0]  q
);

  localparam int N_OUT = N_IN / FANIN;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < N_OUT; i++)
        q[i] <= |d[i*FANIN +: FANIN];
    end
  end

endmodule

// File: rtl/zero_cmp_pipe.sv
// Pipelined zero / equality comparator with valid/ready handshake.
// One OR-tree level per stage, then a registered decode stage.
module zero_cmp_pipe
  import zero_cmp_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int FANIN = 4,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_result,
  output logic             out_zero,
  output logic             out_neg,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LEVELS = levels(WIDTH, FANIN);
  localparam int PW     = padded_width(WIDTH, FANIN);
  localparam int TREE_W = level_offset(WIDTH, FANIN, LEVELS + 1);
  localparam int ROOT   = level_offset(WIDTH, FANIN, LEVELS);

  logic              advance;
  logic [PW-1:0]     v_pad;
  logic [TREE_W-1:0] tree;
  logic [LEVELS:1]   vld;
  cmp_mode_t         mode_q [LEVELS];
  logic [TAG_W-1:0]  tag_q  [LEVELS];
  logic [LEVELS-1:0] neg_q;
  logic              zero_d;
  logic              result_d;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  always_comb begin
    v_pad = '0;
    unique case (1'b1)
      in_mode[1]: v_pad[WIDTH-1:0] = in_a ^ in_b;
      default:    v_pad[WIDTH-1:0] = in_a;
    endcase
  end

  assign tree[PW-1:0] = v_pad;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int W_IN  = level_width(WIDTH, FANIN, k - 1);
    localparam int W_OUT = level_width(WIDTH, FANIN, k);
    localparam int O_IN  = level_offset(WIDTH, FANIN, k - 1);
    localparam int O_OUT = level_offset(WIDTH, FANIN, k);

    or_reduce_stage #(
      .N_IN  (W_IN),
      .FANIN (FANIN)
    ) u_or (
      .clk (clk),
      .en  (advance),
      .d   (tree[O_IN +: W_IN]),
      .q   (tree[O_OUT +: W_OUT])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
    end else if (advance) begin
      vld[1] <= in_valid & in_ready;
      for (int k = 2; k <= LEVELS; k++)
        vld[k] <= vld[k-1];
    end
  end

  // Sideband rides with the tree data and needs no reset.
  always_ff @(posedge clk) begin
    if (advance) begin
      mode_q[0] <= cmp_mode_t'(in_mode);
      tag_q[0]  <= in_tag;
      neg_q[0]  <= in_a[WIDTH-1];
      for (int k = 1; k < LEVELS; k++) begin
        mode_q[k] <= mode_q[k-1];
        tag_q[k]  <= tag_q[k-1];
        neg_q[k]  <= neg_q[k-1];
      end
    end
  end

  assign zero_d = ~tree[ROOT];

  always_comb begin
    result_d = zero_d;
    unique case (mode_q[LEVELS-1])
      ZERO, EQ: result_d = zero_d;
      NZ, NE:   result_d = ~zero_d;
    endcase
  end

  // Bubbles drive zeros so idle outputs never show stale data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_result <= 1'b0;
      out_zero   <= 1'b0;
      out_neg    <= 1'b0;
      out_tag    <= '0;
    end else if (advance) begin
      out_valid  <= vld[LEVELS];
      out_result <= vld[LEVELS] & result_d;
      out_zero   <= vld[LEVELS] & zero_d;
      out_neg    <= vld[LEVELS] & neg_q[LEVELS-1];
      out_tag    <= vld[LEVELS] ? tag_q[LEVELS-1] : '0;
    end
  end

endmodule

// File: tb/tb_zero_cmp_pipe.sv
// Bench for zero_cmp_pipe: cycle model for the default build plus
// directed literal vectors for both the default and a 37/3 build.
module tb_zero_cmp_pipe;
  import zero_cmp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;

  logic        iv = 1'b0;
  logic        ir;
  logic        ordy = 1'b1;
  logic        ov, ores, oz, oneg;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic [1:0]  md = '0;
  logic [4:0]  tg = '0;
  logic [4:0]  otag;

  logic        c_iv = 1'b0;
  logic        c_ir;
  logic        c_ordy = 1'b1;
  logic        c_ov, c_res, c_z, c_neg;
  logic [36:0] c_a = '0;
  logic [36:0] c_b = '0;
  logic [1:0]  c_md = '0;
  logic [4:0]  c_tg = '0;
  logic [4:0]  c_otag;

  zero_cmp_pipe #(.WIDTH(64), .FANIN(4), .TAG_W(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(iv), .in_ready(ir),
    .in_a(a), .in_b(b), .in_mode(md), .in_tag(tg),
    .out_valid(ov), .out_ready(ordy),
    .out_result(ores), .out_zero(oz),
    .out_neg(oneg), .out_tag(otag)
  );

  zero_cmp_pipe #(.WIDTH(37), .FANIN(3), .TAG_W(5)) dut_odd (
    .clk(clk), .reset_n(reset_n),
    .in_valid(c_iv), .in_ready(c_ir),
    .in_a(c_a), .in_b(c_b), .in_mode(c_md), .in_tag(c_tg),
    .out_valid(c_ov), .out_ready(c_ordy),
    .out_result(c_res), .out_zero(c_z),
    .out_neg(c_neg), .out_tag(c_otag)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic       v;
    logic       res;
    logic       zero;
    logic       neg;
    logic [4:0] tag;
  } ent_t;

  function automatic ent_t predict(input logic [63:0] pa,
                                   input logic [63:0] pb,
                                   input logic [1:0]  pm,
                                   input logic [4:0]  pt);
    ent_t e;
    logic [63:0] vv;
    vv     = (pm == EQ || pm == NE) ? (pa ^ pb) : pa;
    e.v    = 1'b1;
    e.zero = (vv == 64'd0);
    e.res  = (pm == ZERO || pm == EQ) ? e.zero : !e.zero;
    e.neg  = pa[63];
    e.tag  = pt;
    return e;
  endfunction

  // Slot 0 = first tree level, slot 3 = the visible output.
  ent_t mp [4];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) mp[i] <= '0;
    end else if (!mp[3].v || ordy) begin
      mp[0] <= iv ? predict(a, b, md, tg) : '0;
      for (int i = 1; i < 4; i++) mp[i] <= mp[i-1];
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("m_in_ready", ir, !mp[3].v || ordy);
      chk("m_out_valid", ov, mp[3].v);
      if (mp[3].v) begin
        chk("m_result", ores, mp[3].res);
        chk("m_zero", oz, mp[3].zero);
        chk("m_neg", oneg, mp[3].neg);
        chk("m_tag", otag, mp[3].tag);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic op1(input logic [63:0] pa, input logic [63:0] pb,
                     input logic [1:0] pm, input logic [4:0] pt,
                     input logic er, input logic ez, input logic en,
                     input string nm);
    a = pa; b = pb; md = pm; tg = pt; iv = 1'b1; ordy = 1'b1;
    tick();
    iv = 1'b0;
    tick();
    tick();
    chk({nm, "_early"}, ov, 1'b0);
    tick();
    chk({nm, "_valid"}, ov, 1'b1);
    chk({nm, "_result"}, ores, er);
    chk({nm, "_zero"}, oz, ez);
    chk({nm, "_neg"}, oneg, en);
    chk({nm, "_tag"}, otag, pt);
    tick();
  endtask

  task automatic op2(input logic [36:0] pa, input logic [36:0] pb,
                     input logic [1:0] pm, input logic [4:0] pt,
                     input logic er, input logic ez, input logic en,
                     input string nm);
    c_a = pa; c_b = pb; c_md = pm; c_tg = pt; c_iv = 1'b1;
    tick();
    c_iv = 1'b0;
    tick();
    tick();
    tick();
    chk({nm, "_early"}, c_ov, 1'b0);
    tick();
    chk({nm, "_valid"}, c_ov, 1'b1);
    chk({nm, "_result"}, c_res, er);
    chk({nm, "_zero"}, c_z, ez);
    chk({nm, "_neg"}, c_neg, en);
    chk({nm, "_tag"}, c_otag, pt);
    tick();
  endtask

  task automatic push1(input logic [63:0] pa, input logic [63:0] pb,
                       input logic [1:0] pm, input logic [4:0] pt,
                       input logic rpat);
    logic acc;
    a = pa; b = pb; md = pm; tg = pt; iv = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) begin
      ordy = rpat | (n > 0);
      #1;
      acc = ir;
      tick();
    end
    if (!acc) chk("push_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  int          cyc [$];
  logic [4:0]  tq [$];
  logic [63:0] hold;

  initial begin
    repeat (3) tick();
    chk("rst_out_valid", ov, 1'b0);
    chk("rst_result", ores, 1'b0);
    chk("rst_zero", oz, 1'b0);
    chk("rst_neg", oneg, 1'b0);
    chk("rst_tag", otag, 5'd0);
    chk("rst_in_ready", ir, 1'b1);
    chk("rst_odd_valid", c_ov, 1'b0);
    chk("rst_odd_tag", c_otag, 5'd0);
    chk("pin_zero", predict(64'd0, 64'd0, ZERO, 5'd3),
        {1'b1, 1'b1, 1'b1, 1'b0, 5'd3});
    chk("pin_ne", predict(64'hDEAD_BEEF_0123_4567,
                          64'hDEAD_BECF_0123_4567, NE, 5'd9),
        {1'b1, 1'b1, 1'b0, 1'b1, 5'd9});
    reset_n = 1'b1;
    tick();

    op1(64'd0, 64'd0, ZERO, 5'd1, 1'b1, 1'b1, 1'b0, "z_a0");
    op1(64'h8000_0000_0000_0000, 64'd0, NZ, 5'd2,
        1'b1, 1'b0, 1'b1, "nz_msb");
    op1(64'd1, 64'd0, ZERO, 5'd3, 1'b0, 1'b0, 1'b0, "z_a1");
    op1(64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, EQ, 5'd4,
        1'b1, 1'b1, 1'b1, "eq_same");
    op1(64'hDEAD_BEEF_0123_4567, 64'hDEAD_BECF_0123_4567, NE, 5'd5,
        1'b1, 1'b0, 1'b1, "ne_b37");
    op1(64'hDEAD_BEEF_0123_4567, 64'hDEAD_BECF_0123_4567, EQ, 5'd6,
        1'b0, 1'b0, 1'b1, "eq_diff");
    op1(64'd0, 64'hFFFF, ZERO, 5'd7, 1'b1, 1'b1, 1'b0, "z_b_ign");

    ordy = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c < 8) begin
        iv = 1'b1; a = 64'(c); b = '0; md = ZERO; tg = 5'(c);
      end else begin
        iv = 1'b0;
      end
      tick();
      if (ov) begin
        cyc.push_back(c);
        tq.push_back(otag);
      end
    end
    chk("b2b_count", 64'(cyc.size()), 64'd8);
    for (int k = 0; k < cyc.size(); k++) begin
      chk("b2b_cycle", 64'(cyc[k]), 64'(k + 3));
      chk("b2b_tag", 64'(tq[k]), 64'(k));
    end

    ordy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      iv = 1'b1; a = 64'(k + 1); b = '0; md = NZ; tg = 5'(10 + k);
      tick();
    end
    chk("bp_full", ov, 1'b1);
    chk("bp_head_tag", otag, 5'd10);
    iv = 1'b1; a = '0; md = ZERO; tg = 5'd14;
    hold = {59'd0, ores, oz, oneg, otag};
    for (int s = 0; s < 4; s++) begin
      #1;
      chk("bp_in_ready", ir, 1'b0);
      tick();
      chk("bp_hold", {59'd0, ores, oz, oneg, otag}, hold);
    end
    ordy = 1'b1;
    tq.delete();
    for (int c = 0; c < 8; c++) begin
      #1;
      if (ov) tq.push_back(otag);
      tick();
      iv = 1'b0;
    end
    chk("bp_drain_count", 64'(tq.size()), 64'd5);
    for (int k = 0; k < tq.size(); k++)
      chk("bp_drain_tag", 64'(tq[k]), 64'(10 + k));

    ordy = 1'b0;
    iv = 1'b1; a = 64'h8000_0000_0000_0000; b = '0; md = NZ; tg = 5'd20;
    tick();
    a = '0; md = ZERO; tg = 5'd21;
    tick();
    iv = 1'b0;
    tick();
    tick();
    chk("rmid_pre_valid", ov, 1'b1);
    chk("rmid_pre_neg", oneg, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk("rmid_valid", ov, 1'b0);
    chk("rmid_result", ores, 1'b0);
    chk("rmid_zero", oz, 1'b0);
    chk("rmid_neg", oneg, 1'b0);
    chk("rmid_tag", otag, 5'd0);
    tick();
    tick();
    reset_n = 1'b1;
    ordy = 1'b1;
    #1;
    chk("rmid_in_ready", ir, 1'b1);
    for (int s = 0; s < 6; s++) begin
      tick();
      chk("rmid_no_stale", ov, 1'b0);
    end

    for (int i = 0; i < 64; i++)
      push1(64'd1 << i, 64'd0, ZERO, 5'(i), (i % 4) != 3);
    for (int i = 0; i < 64; i++)
      push1(64'h0F1E_2D3C_4B5A_6978,
            64'h0F1E_2D3C_4B5A_6978 ^ (64'd1 << i), NE, 5'(i),
            (i % 3) != 0);
    iv = 1'b0;
    ordy = 1'b1;
    repeat (8) tick();

    op2(37'h10_0000_0000, 37'd0, ZERO, 5'd1, 1'b0, 1'b0, 1'b1, "odd_b36");
    op2(37'd0, 37'd0, ZERO, 5'd2, 1'b1, 1'b1, 1'b0, "odd_zero");
    op2(37'h1_2345_6789, 37'h1_2345_6789, EQ, 5'd3,
        1'b1, 1'b1, 1'b0, "odd_eq");
    op2(37'd1, 37'h10_0000_0001, NE, 5'd4, 1'b1, 1'b0, 1'b0, "odd_ne");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
